// File: rtl/da_pkg.sv
// Shared constants and encodings for the DAC-side interpolator.
package da_pkg;

  localparam int unsigned DW = 16;
  localparam int unsigned KW = 3;

  // Upsampling ratio selected by cfg_itp[1:0]; the value is also the shift amount.
  typedef enum logic [1:0] {
    ITP_X1 = 2'd0,
    ITP_X2 = 2'd1,
    ITP_X4 = 2'd2,
    ITP_X8 = 2'd3
  } itp_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    UNDR  = 2'd3
  } state_e;

  // Last interpolation phase (N-1) for a given ratio.
  function automatic logic [KW-1:0] k_last(input itp_e mode);
    case (mode)
      ITP_X1:  k_last = KW'(0);
      ITP_X2:  k_last = KW'(1);
      ITP_X4:  k_last = KW'(3);
      default: k_last = KW'(7);
    endcase
  endfunction

endpackage

// File: rtl/da_interp_alu.sv
// Linear interpolation datapath: out = prev + floor((cur - prev) * k / 2^s).
module da_interp_alu #(
  parameter int unsigned DW = 16,
  parameter int unsigned KW = 3
) (
  input  logic [DW-1:0] prev,
  input  logic [DW-1:0] cur,
  input  logic [KW-1:0] k,
  input  logic [1:0]    s,
  output logic [DW-1:0] out
);

  // Signed difference is DW+1 bits, zero-extended k is KW+1 bits.
  localparam int unsigned PW = DW + KW + 2;

  logic signed [DW:0]   diff;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] step;

  // Result always lies between prev and cur, so plain truncation is exact.
  always_comb begin
    diff = $signed({1'b0, cur}) - $signed({1'b0, prev});
    prod = PW'(diff) * $signed(PW'({1'b0, k}));
    step = prod >>> s;
    out  = DW'(PW'(prev) + step);
  end

endmodule

// File: rtl/da_interp.sv
// DAC-rate interpolator: one-entry input hold register, linear upsampling x1..x8,
// one output per DAC tick, sticky underrun flag.
module da_interp #(
  parameter int unsigned DW = 16,
  parameter int unsigned KW = 3
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic [DW-1:0] da_data_i,
  input  logic          da_vld_i,
  output logic          da_rdy_o,
  input  logic          da_tick_i,
  output logic [DW-1:0] da_data_o,
  output logic          da_vld_o,
  input  logic [7:0]    cfg_itp,
  input  logic          clr_undr_i,
  output logic          undr_o
);

  import da_pkg::*;

  state_e        state;
  itp_e          mode_r;
  logic [DW-1:0] prev;
  logic [DW-1:0] cur;
  logic [DW-1:0] hold;
  logic          hold_vld;
  logic [KW-1:0] k;
  logic [DW-1:0] alu_out;
  logic          k_end;
  logic          consume;
  logic          cfg_unused;

  // Reserved configuration bits have no function.
  assign cfg_unused = ^cfg_itp[7:2];

  assign k_end = (k == k_last(mode_r));

  da_interp_alu #(
    .DW(DW),
    .KW(KW)
  ) u_alu (
    .prev(prev),
    .cur (cur),
    .k   (k),
    .s   (mode_r),
    .out (alu_out)
  );

  // Decide whether the FSM takes the held sample this cycle.
  always_comb begin
    consume = 1'b0;
    case (state)
      EMPTY, FILL, UNDR: consume = hold_vld;
      RUN:               consume = hold_vld & da_tick_i & k_end;
      default:           consume = 1'b0;
    endcase
  end

  // Hold register with registered ready; consume and accept are mutually exclusive.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      hold     <= '0;
      hold_vld <= 1'b0;
      da_rdy_o <= 1'b1;
    end else if (consume) begin
      hold_vld <= 1'b0;
      da_rdy_o <= 1'b1;
    end else if (da_vld_i && da_rdy_o) begin
      hold     <= da_data_i;
      hold_vld <= 1'b1;
      da_rdy_o <= 1'b0;
    end
  end

  // Sample-pair FSM with registered output sample and strobe.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      mode_r    <= ITP_X1;
      prev      <= '0;
      cur       <= '0;
      k         <= '0;
      da_data_o <= '0;
      da_vld_o  <= 1'b0;
    end else begin
      da_vld_o <= 1'b0;
      case (state)
        EMPTY: begin
          mode_r <= itp_e'(cfg_itp[1:0]);
          if (hold_vld) begin
            prev  <= hold;
            state <= FILL;
          end
        end
        FILL: begin
          if (hold_vld) begin
            cur   <= hold;
            k     <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (da_tick_i) begin
            da_data_o <= alu_out;
            da_vld_o  <= 1'b1;
            if (!k_end) begin
              k <= k + KW'(1);
            end else if (hold_vld) begin
              prev   <= cur;
              cur    <= hold;
              k      <= '0;
              mode_r <= itp_e'(cfg_itp[1:0]);
            end else begin
              state <= UNDR;
            end
          end
        end
        UNDR: begin
          // A tick here repeats the old cur even if a new pair is loaded this cycle.
          if (da_tick_i) begin
            da_data_o <= cur;
            da_vld_o  <= 1'b1;
          end
          if (hold_vld) begin
            prev   <= cur;
            cur    <= hold;
            k      <= '0;
            mode_r <= itp_e'(cfg_itp[1:0]);
            state  <= RUN;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // Sticky underrun flag; a tick in UNDR takes priority over the clear.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      undr_o <= 1'b0;
    end else if (state == UNDR && da_tick_i) begin
      undr_o <= 1'b1;
    end else if (clr_undr_i) begin
      undr_o <= 1'b0;
    end
  end

endmodule
